// File: rtl/fifo_width_downsizer.sv
// rtl/fifo_width_downsizer.sv - splits FIFO words into narrower valid/ready slices, LSB- or MSB-first per word
module fifo_width_downsizer #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int CW         = $clog2(DATA_WIDTH / OUT_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid_s,
    input  logic [DATA_WIDTH-1:0] i_datain,
    input  logic                  i_msb_first,
    output logic                  o_ready_s,
    output logic                  o_valid_m,
    output logic [OUT_WIDTH-1:0]  o_dataout,
    output logic                  o_last,
    input  logic                  i_ready_m,
    output logic                  o_busy
);

    localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
    localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]            state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  msb_q;

    logic                  at_last;
    logic                  accept;
    logic                  xfer;
    logic [CW-1:0]         sel_idx;
    logic [OUT_WIDTH-1:0]  slice;

    assign at_last   = (cnt == LAST_IDX);
    assign o_valid_m = (state == SHIFT);
    assign o_busy    = (state == SHIFT);
    assign o_last    = o_valid_m & at_last;

    // A new word may enter when idle, or in the same cycle the final slice leaves;
    // held low during reset so the FIFO is never popped by a block that is not running.
    assign o_ready_s = i_rst_n & ((state == IDLE) | ((state == SHIFT) & at_last & i_ready_m));

    assign accept = i_valid_s & o_ready_s;
    assign xfer   = o_valid_m & i_ready_m;

    // Map the emission counter onto a slice position according to the word's order flag.
    assign sel_idx = msb_q ? (LAST_IDX - cnt) : cnt;

    // Slice multiplexer written as a compare loop so non-power-of-two ratios stay in range.
    always_comb begin
        slice = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (sel_idx == CW'(i)) begin
                slice = data_q[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    assign o_dataout = o_valid_m ? slice : '0;

    // Word capture, slice counting and the IDLE/SHIFT sequencing.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            data_q <= '0;
            msb_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_q <= i_datain;
                        msb_q  <= i_msb_first;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (xfer) begin
                        if (!at_last) begin
                            cnt <= cnt + 1'b1;
                        end else if (accept) begin
                            data_q <= i_datain;
                            msb_q  <= i_msb_first;
                            cnt    <= '0;
                        end else begin
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_width_downsizer.sv
// tb/tb_fifo_width_downsizer.sv - directed self-checking bench for fifo_width_downsizer
module tb_fifo_width_downsizer;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid_s;
    logic [31:0] i_datain;
    logic        i_msb_first;
    logic        o_ready_s;
    logic        o_valid_m;
    logic [7:0]  o_dataout;
    logic        o_last;
    logic        i_ready_m;
    logic        o_busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wq[$];
    logic        mq[$];
    logic [7:0]  eq[$];

    fifo_width_downsizer #(
        .DATA_WIDTH(32),
        .OUT_WIDTH (8)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid_s  (i_valid_s),
        .i_datain   (i_datain),
        .i_msb_first(i_msb_first),
        .o_ready_s  (o_ready_s),
        .o_valid_m  (o_valid_m),
        .o_dataout  (o_dataout),
        .o_last     (o_last),
        .i_ready_m  (i_ready_m),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // mode 0: ready always high; 1: ready toggles 1,0,1,0; 2: ready held low 3 cycles on the first final slice
    task automatic run_stream(input int mode, input int stop_after);
        int idx = 0;
        int cyc = 0;
        int first_acc = -1;
        int first_x = -1;
        int last_x = -1;
        int stall_left = 0;
        bit stall_done = 0;
        bit acc;
        while (idx < eq.size() && cyc < 200 && !(stop_after > 0 && idx >= stop_after)) begin
            @(negedge i_clk);
            i_valid_s   = (wq.size() > 0);
            i_datain    = i_valid_s ? wq[0] : $urandom;
            i_msb_first = i_valid_s ? mq[0] : 1'($urandom);
            case (mode)
                1: i_ready_m = (cyc % 2 == 0);
                2: begin
                    if (o_last && !stall_done && stall_left == 0) stall_left = 3;
                    i_ready_m = (stall_left == 0);
                    if (stall_left > 0) begin
                        stall_left--;
                        if (stall_left == 0) stall_done = 1;
                    end
                end
                default: i_ready_m = 1'b1;
            endcase
            #1;
            if (o_valid_m && i_ready_m) begin
                check("slice", 32'(o_dataout), 32'(eq[idx]));
                check("last", 32'(o_last), 32'(idx % 4 == 3));
                check("ready_s_xfer", 32'(o_ready_s), 32'(idx % 4 == 3));
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
                idx++;
            end else if (o_valid_m) begin
                check("hold_slice", 32'(o_dataout), 32'(eq[idx]));
                check("ready_s_stall", 32'(o_ready_s), 32'd0);
                if (mode == 2 && o_last) check("fifo_occupancy", 32'(wq.size()), 32'd1);
            end else begin
                check("ready_s_idle", 32'(o_ready_s), 32'd1);
                check("busy_idle", 32'(o_busy), 32'd0);
            end
            acc = i_valid_s & o_ready_s;
            if (acc && first_acc < 0) first_acc = cyc;
            @(posedge i_clk);
            if (acc) begin
                void'(wq.pop_front());
                void'(mq.pop_front());
            end
            cyc++;
        end
        if (stop_after > 0) begin
            check("partial_count", 32'(idx), 32'(stop_after));
        end else begin
            check("slice_count", 32'(idx), 32'(eq.size()));
            check("fifo_drained", 32'(wq.size()), 32'd0);
            if (mode == 0) begin
                check("first_latency", 32'(first_x - first_acc), 32'd1);
                check("no_bubble", 32'(last_x - first_x), 32'(eq.size() - 1));
            end
        end
    endtask

    task automatic check_idle();
        @(negedge i_clk);
        i_valid_s = 1'b0;
        i_ready_m = 1'b1;
        #1;
        check("idle_valid", 32'(o_valid_m), 32'd0);
        check("idle_busy", 32'(o_busy), 32'd0);
        check("idle_last", 32'(o_last), 32'd0);
        check("idle_ready_s", 32'(o_ready_s), 32'd1);
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_valid_s   = 1'b1;
        i_datain    = 32'hDEADBEEF;
        i_msb_first = 1'b0;
        i_ready_m   = 1'b0;
        #12;
        check("rst_valid", 32'(o_valid_m), 32'd0);
        check("rst_ready_s", 32'(o_ready_s), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_last", 32'(o_last), 32'd0);
        check("rst_data", 32'(o_dataout), 32'd0);
        @(negedge i_clk);
        i_valid_s = 1'b0;
        i_rst_n   = 1'b1;
        #1;
        check("post_rst_ready_s", 32'(o_ready_s), 32'd1);

        // LSB-first, downstream always ready
        wq = '{32'hAABBCCDD}; mq = '{1'b0};
        eq = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        run_stream(0, 0);
        check_idle();

        // MSB-first with alternating downstream stalls
        wq = '{32'h11223344}; mq = '{1'b1};
        eq = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_stream(1, 0);
        check_idle();

        // Back-to-back words, no bubble across the word boundary
        wq = '{32'h01020304, 32'h05060708}; mq = '{1'b0, 1'b0};
        eq = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05};
        run_stream(0, 0);
        check_idle();

        // Final-slice stall with a word waiting, second word MSB-first
        wq = '{32'h0A0B0C0D, 32'h12345678}; mq = '{1'b0, 1'b1};
        eq = '{8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h12, 8'h34, 8'h56, 8'h78};
        run_stream(2, 0);
        check_idle();

        // Reset in the middle of a word
        wq = '{32'h11223344}; mq = '{1'b0};
        eq = '{8'h44, 8'h33, 8'h22, 8'h11};
        run_stream(0, 2);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(o_valid_m), 32'd0);
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_ready_s", 32'(o_ready_s), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check("midrst_release_ready_s", 32'(o_ready_s), 32'd1);
        wq = '{32'hCAFEBABE}; mq = '{1'b0};
        eq = '{8'hBE, 8'hBA, 8'hFE, 8'hCA};
        run_stream(0, 0);
        check_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_width_downsizer.md
Name: fifo_width_downsizer

Overview:
- Downstream consumer of sync_fifo. Pops DATA_WIDTH-bit words from the FIFO read port (o_valid_m / i_ready_m / o_dataout) and serializes each word into RATIO = DATA_WIDTH/OUT_WIDTH narrower slices on a valid/ready master port.
- Slice order (LSB-first or MSB-first) is selectable per word. Each word's final slice is tagged. Sustains one slice per cycle with no bubble between words.

Parameters:
- DATA_WIDTH, 32: input word width. Must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 8: output slice width. RATIO = DATA_WIDTH/OUT_WIDTH must be >= 2.
- CW, $clog2(DATA_WIDTH/OUT_WIDTH): slice counter width.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous reset, active low
- i_valid_s  input  1  input word valid (driven by FIFO o_valid_m)
- i_datain  input  DATA_WIDTH  input word (driven by FIFO o_dataout)
- i_msb_first  input  1  slice order for the word being accepted: 0 = LSB slice first, 1 = MSB slice first
- o_ready_s  output  1  block can accept a word (drives FIFO i_ready_m)
- o_valid_m  output  1  output slice valid
- o_dataout  output  OUT_WIDTH  output slice
- o_last  output  1  current slice is the final slice of its word
- i_ready_m  input  1  downstream accepts slice
- o_busy  output  1  a word is held and not fully emitted

Behaviour:
- Clock and reset: one clock, i_clk. Asynchronous active-low reset, i_rst_n. All flops are reset asynchronously.
- Reset values:
  - state = IDLE, slice counter = 0, data register = 0, order flag = 0.
  - o_valid_m = 0, o_last = 0, o_busy = 0, o_dataout = 0.
  - o_ready_s is forced to 0 while i_rst_n = 0.
- Handshakes:
  - Input accept occurs when i_valid_s & o_ready_s at a rising edge.
  - Output transfer occurs when o_valid_m & i_ready_m at a rising edge.
- States:
  - IDLE: o_valid_m = 0, o_ready_s = 1. On input accept, register i_datain and i_msb_first, set counter = 0, go to SHIFT.
  - SHIFT: o_valid_m = 1, o_busy = 1.
    - On output transfer with counter < RATIO-1: counter increments.
    - On output transfer with counter = RATIO-1 (final slice):
      - If i_valid_s = 1, load the new word and flag, set counter = 0, stay in SHIFT (back-to-back, no bubble).
      - Otherwise go to IDLE.
    - Without an output transfer, hold all state. o_dataout and o_last are stable while o_valid_m = 1 and i_ready_m = 0.
- o_ready_s = (state == IDLE) | (state == SHIFT & counter == RATIO-1 & i_ready_m). This is a combinational path from i_ready_m to o_ready_s and is accepted by design.
- Slice select, with k = counter:
  - LSB-first: o_dataout = data[k*OUT_WIDTH +: OUT_WIDTH].
  - MSB-first: o_dataout = data[(RATIO-1-k)*OUT_WIDTH +: OUT_WIDTH].
- o_last = o_valid_m & (counter == RATIO-1).
- Latency:
  - A word accepted at edge N presents its first slice from edge N (o_valid_m high in cycle N+1).
  - Full throughput is RATIO slices per RATIO cycles across consecutive words.
- Boundary conditions:
  - Empty upstream (i_valid_s = 0) at the final slice: return to IDLE; o_valid_m drops after the final transfer.
  - Downstream stall on the final slice: o_ready_s = 0, and no word is popped from the FIFO.
  - i_datain and i_msb_first are ignored unless accepted.
  - Counter never exceeds RATIO-1.
  - Reset asserted mid-word: the held word is discarded, and the block is in IDLE immediately (asynchronous reset).

Test Plan:
- Reset then idle: i_rst_n low → o_valid_m = 0, o_ready_s = 0, o_busy = 0. After release, o_ready_s = 1.
- LSB-first, i_ready_m = 1: word 0xAABBCCDD, i_msb_first = 0 → slices 0xDD, 0xCC, 0xBB, 0xAA on 4 consecutive cycles; o_last only on 0xAA; then IDLE.
- MSB-first with stalls: word 0x11223344, i_msb_first = 1, i_ready_m toggling 1,0,1,0… → slices 0x11, 0x22, 0x33, 0x44 in order. Output held stable during each stall.
- Back-to-back from sync_fifo: push 0x01020304 and 0x05060708 into the FIFO, i_ready_m = 1 → 8 slices 04 03 02 01 08 07 06 05 over 8 consecutive cycles. o_ready_s pulses high with the first o_last; FIFO goes empty.
- Final-slice stall: hold i_ready_m = 0 while o_last = 1 and FIFO non-empty → o_ready_s = 0 and FIFO occupancy unchanged until i_ready_m = 1.
- Mid-word reset: assert i_rst_n after 2 of 4 slices → o_valid_m = 0 immediately. After release, the next word starts at slice 0.
